// File: rtl/state_pkg.sv
// Shared definitions for the state-table writer: field layout, table limits and FSM encoding.
package state_pkg;

   localparam int POS_WIDTH   = 4;
   localparam int ADDR_WIDTH  = 12;
   localparam int STATE_WIDTH = POS_WIDTH + ADDR_WIDTH + 1;

   localparam int END_BIT    = 0;
   localparam int PARENT_LSB = 1;
   localparam int PARENT_MSB = PARENT_LSB + ADDR_WIDTH - 1;
   localparam int POS_LSB    = PARENT_MSB + 1;
   localparam int POS_MSB    = POS_LSB + POS_WIDTH - 1;

   localparam logic [ADDR_WIDTH-1:0] NULL_ADDR   = '1;
   localparam logic [ADDR_WIDTH:0]   MAX_ENTRIES = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);
   localparam int                    FIFO_DEPTH  = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_FULL,
      ST_CLEAR
   } wr_state_t;

   function automatic logic [STATE_WIDTH-1:0] pack_state(
      input logic [POS_WIDTH-1:0]  pos,
      input logic [ADDR_WIDTH-1:0] parent,
      input logic                  end_flag
   );
      return {pos, parent, end_flag};
   endfunction

endpackage

// File: rtl/state_req_fifo.sv
// Show-ahead synchronous request FIFO; head is valid whenever empty is low.
module state_req_fifo
   import state_pkg::*;
#(
   parameter int WIDTH = STATE_WIDTH,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_idx_reg;
   logic [AW-1:0]    rd_idx_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign level   = count_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_idx_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_idx_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_idx_reg <= '0;
         rd_idx_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_idx_reg <= wr_idx_reg + 1'b1;
         end
         if (do_pop) begin
            rd_idx_reg <= rd_idx_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/state_push_writer.sv
// Buffers push requests, packs them into state words and appends them to the state table,
// returning the address assigned to each entry and flagging overflow and bad parent links.
module state_push_writer
   import state_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [POS_WIDTH-1:0]   in_pos,
   input  logic [ADDR_WIDTH-1:0]  in_parent_addr,
   input  logic                   in_end,
   output logic                   we,
   output logic [STATE_WIDTH-1:0] w_data,
   output logic                   out_addr_valid,
   output logic [ADDR_WIDTH-1:0]  out_addr,
   output logic [ADDR_WIDTH:0]    wr_count,
   output logic                   full,
   output logic                   overflow,
   output logic                   err_parent
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   wr_state_t               state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   wr_ptr_reg;
   logic [ADDR_WIDTH:0]     wr_count_reg;
   logic                    overflow_reg;
   logic                    err_parent_reg;

   logic                    fifo_full;
   logic                    fifo_empty;
   logic [STATE_WIDTH-1:0]  fifo_head;
   logic [LVL_W-1:0]        fifo_level;
   logic [ADDR_WIDTH-1:0]   head_parent;

   logic table_full;
   logic accept;
   logic do_write;
   logic last_write;
   logic bad_parent;

   assign table_full  = (wr_count_reg == MAX_ENTRIES);
   assign in_ready    = !rst && !fifo_full && !table_full && (state_reg != ST_CLEAR);
   assign accept      = in_valid && in_ready && !clear;
   // clear and rst both suppress the write so a flushed entry never reaches the table
   assign do_write    = !rst && !clear && (state_reg == ST_WRITE) && !fifo_empty && !table_full;
   assign last_write  = do_write && (wr_count_reg == MAX_ENTRIES - (ADDR_WIDTH+1)'(1));
   assign head_parent = fifo_head[PARENT_MSB:PARENT_LSB];
   assign bad_parent  = (head_parent != NULL_ADDR) && (head_parent >= wr_ptr_reg);

   state_req_fifo #(
      .WIDTH (STATE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (clear),
      .push      (accept),
      .push_data (pack_state(in_pos, in_parent_addr, in_end)),
      .pop       (do_write),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (clear) begin
         state_next = ST_CLEAR;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) state_next = ST_WRITE;
            end
            ST_WRITE: begin
               if (last_write) begin
                  state_next = ST_FULL;
               end else if (do_write && !accept && fifo_level == LVL_W'(1)) begin
                  state_next = ST_IDLE;
               end
            end
            ST_FULL:  state_next = ST_FULL;
            ST_CLEAR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr_reg     <= '0;
         wr_count_reg   <= '0;
         overflow_reg   <= 1'b0;
         err_parent_reg <= 1'b0;
      end else begin
         if (do_write) begin
            // pointer saturates at the reserved NULL slot rather than wrapping
            if (wr_ptr_reg != NULL_ADDR) begin
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            wr_count_reg <= wr_count_reg + 1'b1;
            if (bad_parent) begin
               err_parent_reg <= 1'b1;
            end
         end
         if (in_valid && table_full) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign we             = do_write;
   assign out_addr_valid = do_write;
   assign w_data         = do_write ? fifo_head : '0;
   assign out_addr       = wr_ptr_reg;
   assign wr_count       = wr_count_reg;
   assign full           = table_full;
   assign overflow       = overflow_reg;
   assign err_parent     = err_parent_reg;

endmodule

// File: tb/tb_state_push_writer.sv
// Randomised and directed bench for state_push_writer, checked every cycle against a queue-based table model.
module tb_state_push_writer;
   import state_pkg::*;

   logic        clk = 1'b0;
   logic        rst, clear, in_valid, in_end;
   logic [3:0]  in_pos;
   logic [11:0] in_parent_addr;
   logic        in_ready, we, out_addr_valid, full, overflow, err_parent;
   logic [16:0] w_data;
   logic [11:0] out_addr;
   logic [12:0] wr_count;

   always #5 clk = ~clk;

   state_push_writer dut (
      .clk            (clk),
      .rst            (rst),
      .clear          (clear),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pos         (in_pos),
      .in_parent_addr (in_parent_addr),
      .in_end         (in_end),
      .we             (we),
      .w_data         (w_data),
      .out_addr_valid (out_addr_valid),
      .out_addr       (out_addr),
      .wr_count       (wr_count),
      .full           (full),
      .overflow       (overflow),
      .err_parent     (err_parent)
   );

   typedef struct {
      int pos;
      int parent;
      int fin;
   } req_t;

   int   n_checks = 0;
   int   n_pass   = 0;
   req_t q[$];
   int   m_count;
   bit   m_err, m_ovf, m_clr_state;
   logic [16:0] last_w_data;
   logic [11:0] last_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: compare outputs mid-cycle against the model, then advance the model at the edge.
   task automatic step();
      bit exp_ready, exp_we, acc;
      int exp_data;
      @(negedge clk);
      exp_ready = !rst && !m_clr_state && q.size() < FIFO_DEPTH && m_count < 4095;
      exp_we    = !rst && !clear && q.size() > 0 && m_count < 4095;
      check("in_ready", in_ready, exp_ready);
      check("we", we, exp_we);
      check("out_addr_valid", out_addr_valid, exp_we);
      check("out_addr", out_addr, m_count);
      check("wr_count", wr_count, m_count);
      check("full", full, m_count == 4095);
      check("overflow", overflow, m_ovf);
      check("err_parent", err_parent, m_err);
      if (exp_we) begin
         exp_data = q[0].pos * 8192 + q[0].parent * 2 + q[0].fin;
         check("w_data", w_data, exp_data);
      end
      if (rst) check("w_data_rst", w_data, 0);
      if (we) begin
         last_w_data = w_data;
         last_addr   = out_addr;
         $display("write addr=%0d data=%05h", out_addr, w_data);
      end
      acc = in_valid && exp_ready && !clear;
      @(posedge clk);
      if (rst || clear) begin
         q.delete();
         m_count     = 0;
         m_err       = 0;
         m_ovf       = 0;
         m_clr_state = !rst;
      end else begin
         if (in_valid && m_count == 4095) m_ovf = 1;
         if (exp_we) begin
            if (q[0].parent != 4095 && q[0].parent >= m_count) m_err = 1;
            void'(q.pop_front());
            m_count++;
         end
         if (acc) q.push_back('{int'(in_pos), int'(in_parent_addr), int'(in_end)});
         m_clr_state = 0;
      end
      #1;
   endtask

   task automatic push(input int pos, input int parent, input int fin);
      in_valid       = 1'b1;
      in_pos         = 4'(pos);
      in_parent_addr = 12'(parent);
      in_end         = 1'(fin);
      step();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      int guard;
      int r;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
      in_pos = '0; in_parent_addr = '0; in_end = 1'b0;
      last_w_data = '0; last_addr = '0;
      q.delete(); m_count = 0; m_err = 0; m_ovf = 0; m_clr_state = 0;
      @(posedge clk); #1;
      repeat (2) step();
      rst = 1'b0;

      // single root push
      push(3, 12'hFFF, 0);
      idle(2);
      check("t1_w_data", last_w_data, 17'h07FFE);
      check("t1_addr", last_addr, 0);
      check("t1_count", wr_count, 1);

      // back-to-back chain, each parent is the previous entry
      for (int k = 0; k < 8; k++) push((k + 1) % 16, k, k & 1);
      idle(2);
      check("t2_count", wr_count, 9);
      check("t2_err", err_parent, 0);

      // forward parent pointer
      pulse_clear();
      idle(1);
      push(1, 12'hFFF, 0);
      push(2, 0, 0);
      push(4, 5, 1);
      idle(3);
      check("t3_addr", last_addr, 2);
      check("t3_err", err_parent, 1);

      // clear coinciding with an accept and a pending write
      push(5, 12'hFFF, 0);
      in_valid = 1'b1; in_pos = 4'd6; in_parent_addr = 12'd3; in_end = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0; in_valid = 1'b0;
      check("t5_count", wr_count, 0);
      check("t5_err", err_parent, 0);
      idle(1);
      push(7, 12'hFFF, 1);
      idle(2);
      check("t5_addr", last_addr, 0);

      // reset in the middle of a stream
      push(1, 12'hFFF, 0);
      in_valid = 1'b1; rst = 1'b1;
      repeat (2) step();
      rst = 1'b0; in_valid = 1'b0;
      check("t6_count", wr_count, 0);
      push(2, 12'hFFF, 1);
      idle(2);
      check("t6_addr", last_addr, 0);

      // randomised traffic with occasional clear and reset
      for (int i = 0; i < 500; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         clear    = ($urandom_range(0, 39) == 0);
         rst      = ($urandom_range(0, 149) == 0);
         in_pos   = 4'($urandom_range(0, 15));
         in_end   = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 3);
         if (r == 0 || m_count == 0) in_parent_addr = 12'hFFF;
         else if (r == 1)            in_parent_addr = 12'($urandom_range(0, 4095));
         else                        in_parent_addr = 12'($urandom_range(0, m_count - 1));
         step();
      end
      rst = 1'b0; clear = 1'b0;
      idle(2);

      // fill the table to capacity
      pulse_clear();
      idle(1);
      guard = 0;
      while (m_count < 4095 && guard < 5000) begin
         push($urandom_range(0, 15), (m_count == 0) ? 12'hFFF : m_count - 1, $urandom_range(0, 1));
         guard++;
      end
      idle(2);
      check("t4_full", full, 1);
      check("t4_count", wr_count, 4095);
      check("t4_err", err_parent, 0);
      in_valid = 1'b1; in_pos = 4'd2; in_parent_addr = 12'd7; in_end = 1'b0;
      repeat (3) step();
      in_valid = 1'b0;
      check("t4_ovf", overflow, 1);
      check("t4_ready", in_ready, 0);
      pulse_clear();
      check("t4_clr_full", full, 0);
      check("t4_clr_ovf", overflow, 0);
      idle(1);
      push(9, 12'hFFF, 0);
      idle(2);
      check("t4_addr", last_addr, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
